// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the out-of-order memory units: lw/sw opcodes,
// FSM state encoding and the CDB result record.
package mem_access_unit_pkg;

  localparam logic [11:0] OP_LW = 12'h003;
  localparam logic [11:0] OP_SW = 12'h023;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mau_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  roben;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        exc;
  } cdb_t;

  function automatic logic is_mem_op(input logic [11:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Single-entry load/store engine: issues one memory request, waits for
// ack (with timeout), then holds the result on the CDB until granted.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 VALID_Inst,
  input  logic [4:0]           ROBEN,
  input  logic [4:0]           Rd,
  input  logic [11:0]          opcode,
  input  logic [31:0]          EA,
  input  logic [31:0]          Write_Data,
  input  logic                 ROB_FLUSH_Flag,
  output logic                 out_BUSY,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  input  logic                 CDB_grant,
  output logic                 out_CDB_VALID,
  output logic [4:0]           out_CDB_ROBEN,
  output logic [4:0]           out_CDB_Rd,
  output logic [31:0]          out_CDB_VAL,
  output logic                 out_CDB_EXCEPTION
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  mau_state_e           state, state_nxt;
  logic                 busy_nxt, req_nxt, we_nxt;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [31:0]          wdata_nxt;
  logic [WW-1:0]        wait_cnt, wait_nxt;
  cdb_t                 cdb, cdb_nxt;
  logic                 ea_fault;

  // Only byte addresses below 2^ADDR_BITS and word-aligned are legal.
  assign ea_fault = ((EA >> ADDR_BITS) != 32'd0) || (EA[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    wait_nxt  = wait_cnt;
    cdb_nxt   = cdb;
    if (ROB_FLUSH_Flag) begin
      state_nxt = S_IDLE;
      req_nxt   = 1'b0;
      wait_nxt  = '0;
      cdb_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (VALID_Inst && is_mem_op(opcode)) begin
            cdb_nxt.roben = ROBEN;
            cdb_nxt.rd    = Rd;
            cdb_nxt.val   = 32'd0;
            wait_nxt      = '0;
            if (ea_fault) begin
              state_nxt     = S_RESP;
              cdb_nxt.valid = 1'b1;
              cdb_nxt.exc   = 1'b1;
            end else begin
              state_nxt     = S_REQ;
              req_nxt       = 1'b1;
              addr_nxt      = EA[ADDR_BITS+1:2];
              we_nxt        = (opcode == OP_SW);
              wdata_nxt     = Write_Data;
              cdb_nxt.valid = 1'b0;
              cdb_nxt.exc   = 1'b0;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state_nxt     = S_RESP;
            req_nxt       = 1'b0;
            cdb_nxt.valid = 1'b1;
            cdb_nxt.exc   = 1'b0;
            cdb_nxt.val   = mem_we ? 32'd0 : mem_rdata;
          end else if (wait_cnt >= WW'(MAX_WAIT - 1)) begin
            // MAX_WAIT cycles of mem_req without ack: give up
            state_nxt     = S_RESP;
            req_nxt       = 1'b0;
            wait_nxt      = WW'(MAX_WAIT);
            cdb_nxt.valid = 1'b1;
            cdb_nxt.exc   = 1'b1;
            cdb_nxt.val   = 32'd0;
          end else begin
            wait_nxt = wait_cnt + WW'(1);
          end
        end
        S_RESP: begin
          if (CDB_grant) begin
            state_nxt     = S_IDLE;
            cdb_nxt.valid = 1'b0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
          cdb_nxt   = '0;
        end
      endcase
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_BUSY  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      cdb       <= '0;
    end else begin
      state     <= state_nxt;
      out_BUSY  <= busy_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      wait_cnt  <= wait_nxt;
      cdb       <= cdb_nxt;
    end
  end

  assign out_CDB_VALID     = cdb.valid;
  assign out_CDB_ROBEN     = cdb.roben;
  assign out_CDB_Rd        = cdb.rd;
  assign out_CDB_VAL       = cdb.val;
  assign out_CDB_EXCEPTION = cdb.exc;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: data-memory word-address width.
REQ-002 SHALL have parameter MAX_WAIT, default 15: cycles without mem_ack before the request is abandoned.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 VALID_Inst  in  1  issued load/store present from the load/store buffer.
REQ-007 ROBEN  in  5  ROB entry of the issued op.
REQ-008 Rd  in  5  destination register.
REQ-009 opcode  in  12  lw or sw.
REQ-010 EA  in  32  effective address.
REQ-011 Write_Data  in  32  store data.
REQ-012 ROB_FLUSH_Flag  in  1  pipeline flush.
REQ-013 out_BUSY  out  1  unit cannot accept an op this cycle.
REQ-014 mem_req, mem_we  out  1 each  memory request and write enable.
REQ-015 mem_addr  out  ADDR_BITS  word address.
REQ-016 mem_wdata  out  32  store data.
REQ-017 mem_ack  in  1  memory completed the request.
REQ-018 mem_rdata  in  32  load data, valid with mem_ack.
REQ-019 CDB_grant  in  1  CDB arbiter accepts the held result.
REQ-020 out_CDB_VALID  out  1  result held for broadcast.
REQ-021 out_CDB_ROBEN  out  5  ROB entry of the result.
REQ-022 out_CDB_Rd  out  5  destination register.
REQ-023 out_CDB_VAL  out  32  load data, or 0 for a store.
REQ-024 out_CDB_EXCEPTION  out  1  address fault.

Function
REQ-025 SHALL implement states IDLE, REQ and RESP; all outputs SHALL be registered; out_BUSY SHALL be (state != IDLE).
REQ-026 IDLE: an op SHALL be captured on VALID_Inst with opcode in {lw, sw}; any other opcode SHALL be ignored.
REQ-027 Capture with EA[31:ADDR_BITS] nonzero or EA[1:0] nonzero SHALL go directly to RESP with out_CDB_EXCEPTION=1, out_CDB_VAL=0, and no memory access.
REQ-028 Otherwise, capture SHALL go to REQ with mem_req=1, mem_addr=EA[ADDR_BITS+1:2], mem_we=(opcode==sw), mem_wdata=Write_Data.
REQ-029 REQ: mem_req and the request fields SHALL be held stable until mem_ack.
REQ-030 On mem_ack in REQ, the next edge SHALL drop mem_req and enter RESP; out_CDB_VAL SHALL be mem_rdata for lw and 0 for sw.
REQ-031 A saturating wait counter SHALL run in REQ; on reaching MAX_WAIT without mem_ack, the unit SHALL drop mem_req and enter RESP with out_CDB_EXCEPTION=1.
REQ-032 RESP: out_CDB_VALID SHALL stay 1 with all CDB fields stable until CDB_grant; on the edge with CDB_grant the unit SHALL clear out_CDB_VALID and go to IDLE.
REQ-033 Minimum latency SHALL be: capture edge, REQ, mem_ack at the first REQ cycle, out_CDB_VALID high two cycles after capture.
REQ-034 ROB_FLUSH_Flag SHALL win over every other event in every state: the next edge SHALL enter IDLE with mem_req=0, out_CDB_VALID=0 and the held result discarded.
REQ-035 A flush coincident with mem_ack SHALL discard the result; a store already acknowledged is not undone.
REQ-036 VALID_Inst SHALL be ignored whenever out_BUSY=1 or ROB_FLUSH_Flag=1; the sender holds it.

Reset
REQ-037 rst SHALL force state=IDLE, out_BUSY=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_CDB_VALID=0, out_CDB_ROBEN=0, out_CDB_Rd=0, out_CDB_VAL=0, out_CDB_EXCEPTION=0 and wait counter=0, immediately and independent of clk.
REQ-038 rst asserted mid-request SHALL abandon the request with no retry after release.

Structure
REQ-039 The lw/sw opcode constants and state encodings SHALL come from the shared opcodes include used by the other out-of-order units.
REQ-040 No sub-module; ADDR_BITS and MAX_WAIT SHALL be the only parameters.

Verification
REQ-041 lw with ROBEN=3, EA=0x10, mem_ack one cycle later with rdata=0xDEADBEEF, grant held high -> mem_addr=4, out_CDB_VALID for one cycle with ROBEN=3, VAL=0xDEADBEEF.
REQ-042 sw with EA=0x8, Write_Data=0x55, mem_ack after 3 cycles -> mem_we=1, mem_addr=2, stable 3 cycles; CDB VAL=0.
REQ-043 lw with EA=0x1000 (ADDR_BITS=10) -> no mem_req; next cycle out_CDB_VALID=1 with EXCEPTION=1.
REQ-044 lw, never ack -> mem_req drops after 15 cycles and an EXCEPTION result appears; CDB_grant held low 5 cycles -> fields stable throughout.
REQ-045 Flush in REQ coincident with mem_ack, and flush alongside VALID_Inst in IDLE -> IDLE next cycle, no CDB output, no capture.
REQ-046 rst pulse between clock edges during REQ -> all outputs zero immediately.
